// File: rtl/parity_pkg.sv
// Shared definitions for the parity stream checker: mode encodings,
// frame FSM state type and the per-word parity error rule.
package parity_pkg;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic {
      IDLE     = 1'b0,
      IN_FRAME = 1'b1
   } frame_state_t;

   // A word is in error when its transmitted parity bit disagrees with the
   // parity expected for the selected mode.
   function automatic logic parity_error(input logic data_xor,
                                         input logic parity,
                                         input logic mode);
      logic err;
      err = data_xor ^ parity;
      if (mode == PAR_ODD) begin
         err = ~err;
      end
      return err;
   endfunction

endpackage

// File: rtl/parity_gen.sv
// Combinational parity generator: reduction XOR over a data word.
module parity_gen #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   output logic              parity
);

   // Parity is 1 when the word holds an odd number of ones.
   always_comb begin
      parity = ^data;
   end

endmodule

// File: rtl/parity_stream_checker.sv
// Streaming parity checker with a one-entry output register, per-frame
// error accumulation, a saturating error counter and a sticky error flag.
module parity_stream_checker
   import parity_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode_odd,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_parity,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic              out_last,
   output logic              out_frame_err,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              err_sticky
);

   frame_state_t state;
   frame_state_t state_next;
   logic         data_xor;
   logic         accept;
   logic         word_err;
   logic         frame_err_acc;
   logic         frame_err_next;

   parity_gen #(
      .DATA_W(DATA_W)
   ) u_parity_gen (
      .data   (in_data),
      .parity (data_xor)
   );

   // The output register can take a new word when empty or being drained.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign word_err = parity_error(data_xor, in_parity, mode_odd);

   // The accumulator only carries history while a frame is open, so a word
   // arriving in IDLE starts its frame with a clean slate.
   assign frame_err_next = ((state == IN_FRAME) && frame_err_acc) || word_err;

   // Frame state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Frame boundaries follow in_last of each accepted word.
   always_comb begin
      state_next = state;
      if (accept) begin
         state_next = in_last ? IDLE : IN_FRAME;
      end
   end

   // Frame error accumulator; emptied when the closing word is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_err_acc <= 1'b0;
      end else if (accept) begin
         frame_err_acc <= in_last ? 1'b0 : frame_err_next;
      end
   end

   // One-entry output register; a new word may replace a consumed one in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_err       <= 1'b0;
         out_last      <= 1'b0;
         out_frame_err <= 1'b0;
      end else if (accept) begin
         out_valid     <= 1'b1;
         out_data      <= in_data;
         out_err       <= word_err;
         out_last      <= in_last;
         out_frame_err <= in_last && frame_err_next;
      end else if (out_ready) begin
         out_valid     <= 1'b0;
      end
   end

   // Error statistics; a clear never swallows an error arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_cnt    <= '0;
         err_sticky <= 1'b0;
      end else if (clr) begin
         err_cnt    <= (accept && word_err) ? CNT_W'(1) : '0;
         err_sticky <= accept && word_err;
      end else if (accept && word_err) begin
         if (!(&err_cnt)) begin
            err_cnt <= err_cnt + CNT_W'(1);
         end
         err_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed self-checking bench for parity_stream_checker. A second instance
// with a 2-bit counter shares all inputs to exercise counter saturation.
module tb_parity_stream_checker;
   import parity_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode_odd;
   logic        clr;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_parity;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_err;
   logic        out_last;
   logic        out_frame_err;
   logic [15:0] err_cnt;
   logic        err_sticky;

   logic        in_ready2;
   logic        out_valid2;
   logic [7:0]  out_data2;
   logic        out_err2;
   logic        out_last2;
   logic        out_frame_err2;
   logic [1:0]  err_cnt2;
   logic        err_sticky2;

   int num_checks = 0;
   int num_fails  = 0;

   parity_stream_checker #(
      .DATA_W(8),
      .CNT_W (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mode_odd      (mode_odd),
      .clr           (clr),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_parity     (in_parity),
      .in_last       (in_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_err       (out_err),
      .out_last      (out_last),
      .out_frame_err (out_frame_err),
      .err_cnt       (err_cnt),
      .err_sticky    (err_sticky)
   );

   parity_stream_checker #(
      .DATA_W(8),
      .CNT_W (2)
   ) dut_sat (
      .clk           (clk),
      .rst_n         (rst_n),
      .mode_odd      (mode_odd),
      .clr           (clr),
      .in_valid      (in_valid),
      .in_ready      (in_ready2),
      .in_data       (in_data),
      .in_parity     (in_parity),
      .in_last       (in_last),
      .out_valid     (out_valid2),
      .out_ready     (out_ready),
      .out_data      (out_data2),
      .out_err       (out_err2),
      .out_last      (out_last2),
      .out_frame_err (out_frame_err2),
      .err_cnt       (err_cnt2),
      .err_sticky    (err_sticky2)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic parity,
                                input logic last, input logic mode);
      in_valid  = 1'b1;
      in_data   = data;
      in_parity = parity;
      in_last   = last;
      mode_odd  = mode;
      tick();
      in_valid  = 1'b0;
   endtask

   // Checks the result register contents of the main instance.
   task automatic checkResult(input string tag, input logic [7:0] data,
                              input logic err, input logic last, input logic ferr);
      checkOutput({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
      checkOutput({tag, "_data"},  64'(out_data), 64'(data));
      checkOutput({tag, "_err"},   64'(out_err), 64'(err));
      checkOutput({tag, "_last"},  64'(out_last), 64'(last));
      checkOutput({tag, "_ferr"},  64'(out_frame_err), 64'(ferr));
   endtask

   initial begin
      rst_n     = 1'b0;
      mode_odd  = PAR_EVEN;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_parity = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();

      // Reset state.
      checkOutput("rst_valid", 64'(out_valid), 64'(1'b0));
      checkOutput("rst_data", 64'(out_data), 64'(8'h00));
      checkOutput("rst_ferr", 64'(out_frame_err), 64'(1'b0));
      checkOutput("rst_cnt", 64'(err_cnt), 64'(16'd0));
      checkOutput("rst_sticky", 64'(err_sticky), 64'(1'b0));
      rst_n = 1'b1;
      #1;
      checkOutput("rst_in_ready", 64'(in_ready), 64'(1'b1));

      // Even mode: 3C has four ones (clean), 1C has three ones (error).
      applyStimulus(8'h3C, 1'b0, 1'b1, PAR_EVEN);
      checkResult("even_3c", 8'h3C, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b1, PAR_EVEN);
      checkResult("even_1c", 8'h1C, 1'b1, 1'b1, 1'b1);
      checkOutput("even_cnt", 64'(err_cnt), 64'(16'd1));
      checkOutput("even_sticky", 64'(err_sticky), 64'(1'b1));

      // Odd mode: 3D has five ones (clean with parity 0), A5 has four (error).
      applyStimulus(8'h3D, 1'b0, 1'b1, PAR_ODD);
      checkResult("odd_3d", 8'h3D, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'hA5, 1'b0, 1'b1, PAR_ODD);
      checkResult("odd_a5", 8'hA5, 1'b1, 1'b1, 1'b1);
      checkOutput("odd_cnt", 64'(err_cnt), 64'(16'd2));

      // Clear coinciding with an erroneous word keeps that error.
      clr = 1'b1;
      applyStimulus(8'h1C, 1'b0, 1'b1, PAR_EVEN);
      checkOutput("clr_err_cnt", 64'(err_cnt), 64'(16'd1));
      checkOutput("clr_err_sticky", 64'(err_sticky), 64'(1'b1));
      checkOutput("clr_err_out", 64'(out_err), 64'(1'b1));
      // Clear alone empties stats; the pending result drains normally.
      tick();
      clr = 1'b0;
      checkOutput("clr_cnt", 64'(err_cnt), 64'(16'd0));
      checkOutput("clr_sticky", 64'(err_sticky), 64'(1'b0));
      checkOutput("drain_valid", 64'(out_valid), 64'(1'b0));

      // Backpressure: the first word is held while the next waits upstream.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      in_parity = 1'b0;
      in_last   = 1'b1;
      mode_odd  = PAR_EVEN;
      tick();
      checkResult("bp_w1", 8'h11, 1'b0, 1'b1, 1'b0);
      checkOutput("bp_ready_low", 64'(in_ready), 64'(1'b0));
      in_data = 8'h22;
      tick();
      checkOutput("bp_hold1", 64'(out_data), 64'(8'h11));
      tick();
      checkOutput("bp_hold2", 64'(out_data), 64'(8'h11));
      checkOutput("bp_hold_valid", 64'(out_valid), 64'(1'b1));
      out_ready = 1'b1;
      #1;
      checkOutput("bp_ready_high", 64'(in_ready), 64'(1'b1));
      tick();
      checkResult("bp_w2", 8'h22, 1'b0, 1'b1, 1'b0);
      in_data = 8'h33;
      tick();
      checkResult("bp_w3", 8'h33, 1'b0, 1'b1, 1'b0);
      in_valid = 1'b0;
      tick();
      checkOutput("bp_empty", 64'(out_valid), 64'(1'b0));

      // Three-word frame with an error on word 2.
      applyStimulus(8'h11, 1'b0, 1'b0, PAR_EVEN);
      checkResult("fr_w1", 8'h11, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b0, PAR_EVEN);
      checkResult("fr_w2", 8'h1C, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h22, 1'b0, 1'b1, PAR_EVEN);
      checkResult("fr_w3", 8'h22, 1'b0, 1'b1, 1'b1);
      applyStimulus(8'h3C, 1'b0, 1'b1, PAR_EVEN);
      checkResult("fr_single", 8'h3C, 1'b0, 1'b1, 1'b0);
      checkOutput("fr_cnt", 64'(err_cnt), 64'(16'd1));

      // Mode switch mid-frame: each word is judged by its own mode.
      applyStimulus(8'h3D, 1'b1, 1'b0, PAR_EVEN);
      checkResult("mode_w1", 8'h3D, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h3D, 1'b0, 1'b1, PAR_ODD);
      checkResult("mode_w2", 8'h3D, 1'b0, 1'b1, 1'b0);

      // Reset mid-frame with a pending result and a dirty accumulator.
      applyStimulus(8'h11, 1'b0, 1'b0, PAR_EVEN);
      applyStimulus(8'h1C, 1'b0, 1'b0, PAR_EVEN);
      out_ready = 1'b0;
      rst_n     = 1'b0;
      tick();
      checkOutput("mrst_valid", 64'(out_valid), 64'(1'b0));
      checkOutput("mrst_data", 64'(out_data), 64'(8'h00));
      checkOutput("mrst_err", 64'(out_err), 64'(1'b0));
      checkOutput("mrst_last", 64'(out_last), 64'(1'b0));
      checkOutput("mrst_ferr", 64'(out_frame_err), 64'(1'b0));
      checkOutput("mrst_cnt", 64'(err_cnt), 64'(16'd0));
      checkOutput("mrst_sticky", 64'(err_sticky), 64'(1'b0));
      checkOutput("mrst_ready", 64'(in_ready), 64'(1'b1));
      rst_n     = 1'b1;
      out_ready = 1'b1;
      applyStimulus(8'h3C, 1'b0, 1'b1, PAR_EVEN);
      checkResult("mrst_new", 8'h3C, 1'b0, 1'b1, 1'b0);

      // Five erroneous words: the 2-bit counter sticks at 3.
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(8'h1C, 1'b0, 1'b1, PAR_EVEN);
         checkOutput($sformatf("sat_cnt16_%0d", i), 64'(err_cnt), 64'(i));
         checkOutput($sformatf("sat_cnt2_%0d", i), 64'(err_cnt2), 64'((i > 3) ? 3 : i));
      end
      checkOutput("sat_valid2", 64'(out_valid2), 64'(1'b1));
      checkOutput("sat_data2", 64'(out_data2), 64'(8'h1C));
      checkOutput("sat_err2", 64'(out_err2), 64'(1'b1));
      checkOutput("sat_last2", 64'(out_last2), 64'(1'b1));
      checkOutput("sat_ferr2", 64'(out_frame_err2), 64'(1'b1));
      checkOutput("sat_sticky2", 64'(err_sticky2), 64'(1'b1));
      checkOutput("sat_ready2", 64'(in_ready2), 64'(1'b1));

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
